// File: rtl/ahb_write_sequencer_if.sv
// Requester handshakes and AHB write-slave bus lines of the write sequencer.
// master: the sequencer side; slave: requesters, stall source and write slave.
interface ahb_write_sequencer_if #(
    parameter int DATA_W = 8,
    parameter int SIZE_W = 5
);
    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_p0;
    logic [DATA_W-1:0] req0_p1;
    logic [SIZE_W-1:0] req0_size;
    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_p0;
    logic [DATA_W-1:0] req1_p1;
    logic [SIZE_W-1:0] req1_size;
    logic              bus_stall;
    logic              hsel_x;
    logic              hwrite;
    logic              hready;
    logic [1:0]        write_select;
    logic [DATA_W-1:0] hwdata;
    logic              busy;
    logic              done;
    logic              done_id;

    modport master (
        input  req0_valid, req0_p0, req0_p1, req0_size,
        input  req1_valid, req1_p0, req1_p1, req1_size,
        input  bus_stall,
        output req0_ready, req1_ready,
        output hsel_x, hwrite, hready, write_select, hwdata,
        output busy, done, done_id
    );

    modport slave (
        output req0_valid, req0_p0, req0_p1, req0_size,
        output req1_valid, req1_p0, req1_p1, req1_size,
        output bus_stall,
        input  req0_ready, req1_ready,
        input  hsel_x, hwrite, hready, write_select, hwdata,
        input  busy, done, done_id
    );
endinterface

// File: rtl/ahb_write_sequencer.sv
// Round-robin sharing of the AHB write slave between two requesters.
// Ports: hclk, hreset_n (async active-low), bus (requesters + slave bus).
module ahb_write_sequencer #(
    parameter int DATA_W = 8,
    parameter int SIZE_W = 5
) (
    input  logic                   hclk,
    input  logic                   hreset_n,
    ahb_write_sequencer_if.master  bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_SIZE,
        S_P0,
        S_P1,
        S_DONE
    } state_t;

    state_t            r_state;
    logic              r_rr_last;
    logic              r_id;
    logic [DATA_W-1:0] r_p0;
    logic [DATA_W-1:0] r_p1;
    logic              r_hsel;
    logic              r_hwrite;
    logic [1:0]        r_ws;
    logic [DATA_W-1:0] r_hwdata;
    logic              r_done;
    logic              r_done_id;

    logic              w_idle;
    logic              w_beat;
    logic              w_grant;
    logic              w_rdy0;
    logic              w_rdy1;
    logic              w_hs;
    logic [DATA_W-1:0] w_p0;
    logic [DATA_W-1:0] w_p1;
    logic [DATA_W-1:0] w_size;

    assign w_idle = (r_state == S_IDLE);
    assign w_beat = (r_state == S_SIZE) || (r_state == S_P0) ||
                    (r_state == S_P1);

    // On a tie the requester not served last wins.
    assign w_grant = (bus.req0_valid && bus.req1_valid) ? ~r_rr_last
                                                        : bus.req1_valid;
    assign w_rdy0  = w_idle && bus.req0_valid && !w_grant;
    assign w_rdy1  = w_idle && bus.req1_valid && w_grant;
    assign w_hs    = w_rdy0 || w_rdy1;

    assign w_p0   = w_grant ? bus.req1_p0 : bus.req0_p0;
    assign w_p1   = w_grant ? bus.req1_p1 : bus.req0_p1;
    // Zero-extend the size field into the data lane.
    assign w_size = w_grant ? DATA_W'(bus.req1_size)
                            : DATA_W'(bus.req0_size);

    assign bus.req0_ready   = w_rdy0;
    assign bus.req1_ready   = w_rdy1;
    assign bus.hready       = w_beat && !bus.bus_stall;
    assign bus.hsel_x       = r_hsel;
    assign bus.hwrite       = r_hwrite;
    assign bus.write_select = r_ws;
    assign bus.hwdata       = r_hwdata;
    assign bus.busy         = !w_idle;
    assign bus.done         = r_done;
    assign bus.done_id      = r_done_id;

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            r_state   <= S_IDLE;
            r_rr_last <= 1'b1;
            r_id      <= 1'b0;
            r_p0      <= '0;
            r_p1      <= '0;
            r_hsel    <= 1'b0;
            r_hwrite  <= 1'b0;
            r_ws      <= 2'd0;
            r_hwdata  <= '0;
            r_done    <= 1'b0;
            r_done_id <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_hs) begin
                        r_id     <= w_grant;
                        r_p0     <= w_p0;
                        r_p1     <= w_p1;
                        r_hsel   <= 1'b1;
                        r_hwrite <= 1'b1;
                        r_ws     <= 2'd2;
                        r_hwdata <= w_size;
                        r_state  <= S_SIZE;
                    end
                end
                S_SIZE: begin
                    if (!bus.bus_stall) begin
                        r_ws     <= 2'd0;
                        r_hwdata <= r_p0;
                        r_state  <= S_P0;
                    end
                end
                S_P0: begin
                    if (!bus.bus_stall) begin
                        r_ws     <= 2'd1;
                        r_hwdata <= r_p1;
                        r_state  <= S_P1;
                    end
                end
                S_P1: begin
                    if (!bus.bus_stall) begin
                        r_hsel    <= 1'b0;
                        r_hwrite  <= 1'b0;
                        r_ws      <= 2'd0;
                        r_hwdata  <= '0;
                        r_done    <= 1'b1;
                        r_done_id <= r_id;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done    <= 1'b0;
                    r_done_id <= 1'b0;
                    r_rr_last <= r_id;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ahb_write_sequencer.sv
// Scoreboard bench for ahb_write_sequencer.
// Handshakes push expected beats/done IDs; the monitor pops and compares.
module tb_ahb_write_sequencer;
    typedef struct packed {
        logic [1:0] ws;
        logic [7:0] d;
    } beat_t;

    logic hclk;
    logic hreset_n;

    ahb_write_sequencer_if #(.DATA_W(8), .SIZE_W(5)) bus_if ();

    ahb_write_sequencer #(.DATA_W(8), .SIZE_W(5)) dut (
        .hclk     (hclk),
        .hreset_n (hreset_n),
        .bus      (bus_if)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    int    n_chk;
    int    n_err;
    int    cyc;
    int    hs_count;
    int    done_cnt;
    int    done_cyc;
    int    hs_cyc;
    int    p0_writes;
    int    both_rdy;
    logic  m_rr;
    logic [7:0] sregs [0:2];
    beat_t beat_q [$];
    logic  done_q [$];
    logic  grants [$];
    int    hs_cycq [$];

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge hclk) cyc <= cyc + 1;

    // Monitor: readiness model, bus qualifiers, write and done scoreboard.
    always @(negedge hclk) begin
        if (hreset_n) begin
            logic v0, v1, g, beat;
            beat_t b;
            logic e;
            v0 = bus_if.req0_valid;
            v1 = bus_if.req1_valid;
            g  = (v0 && v1) ? !m_rr : v1;
            check("rdy0", bus_if.req0_ready, !bus_if.busy && v0 && !g);
            check("rdy1", bus_if.req1_ready, !bus_if.busy && v1 && g);
            if (bus_if.req0_ready && bus_if.req1_ready) both_rdy++;
            beat = bus_if.busy && !bus_if.done;
            check("hsel", bus_if.hsel_x, beat);
            check("hwrite", bus_if.hwrite, beat);
            check("hready", bus_if.hready, beat && !bus_if.bus_stall);
            if (bus_if.req0_valid && bus_if.req0_ready) begin
                beat_q.push_back({2'd2, 8'(bus_if.req0_size)});
                beat_q.push_back({2'd0, bus_if.req0_p0});
                beat_q.push_back({2'd1, bus_if.req0_p1});
                done_q.push_back(1'b0);
                grants.push_back(1'b0);
                hs_count++;
                hs_cyc = cyc + 1;
                hs_cycq.push_back(cyc + 1);
            end
            if (bus_if.req1_valid && bus_if.req1_ready) begin
                beat_q.push_back({2'd2, 8'(bus_if.req1_size)});
                beat_q.push_back({2'd0, bus_if.req1_p0});
                beat_q.push_back({2'd1, bus_if.req1_p1});
                done_q.push_back(1'b1);
                grants.push_back(1'b1);
                hs_count++;
                hs_cyc = cyc + 1;
                hs_cycq.push_back(cyc + 1);
            end
            if (bus_if.hsel_x && bus_if.hwrite && bus_if.hready) begin
                check("beat_expected", beat_q.size() != 0, 1);
                if (beat_q.size() != 0) begin
                    b = beat_q.pop_front();
                    check("write_select", bus_if.write_select, b.ws);
                    check("hwdata", bus_if.hwdata, b.d);
                end
                if (bus_if.write_select < 2'd3)
                    sregs[bus_if.write_select] = bus_if.hwdata;
                if (bus_if.write_select == 2'd0) p0_writes++;
            end
            if (bus_if.done) begin
                check("done_expected", done_q.size() != 0, 1);
                if (done_q.size() != 0) begin
                    e = done_q.pop_front();
                    check("done_id", bus_if.done_id, e);
                    m_rr = e;
                end
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic send(bit id, logic [7:0] p0, logic [7:0] p1,
                        logic [4:0] sz);
        bit ok;
        ok = 0;
        if (id) begin
            bus_if.req1_p0 = p0;
            bus_if.req1_p1 = p1;
            bus_if.req1_size = sz;
            bus_if.req1_valid = 1'b1;
        end else begin
            bus_if.req0_p0 = p0;
            bus_if.req0_p1 = p1;
            bus_if.req0_size = sz;
            bus_if.req0_valid = 1'b1;
        end
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge hclk);
            ok = id ? bus_if.req1_ready : bus_if.req0_ready;
            @(posedge hclk);
            #1;
        end
        bus_if.req0_valid = 1'b0;
        bus_if.req1_valid = 1'b0;
        check("handshake_timeout", ok, 1);
    endtask

    task automatic wait_done(int n);
        int k;
        k = 0;
        while (done_cnt < n && k < 100) begin
            @(posedge hclk);
            #1;
            k++;
        end
        check("done_timeout", done_cnt >= n, 1);
        @(posedge hclk);
        #1;
    endtask

    initial begin
        int base;
        int dc;
        n_chk = 0;
        n_err = 0;
        cyc = 0;
        hs_count = 0;
        done_cnt = 0;
        p0_writes = 0;
        both_rdy = 0;
        m_rr = 1'b1;
        for (int i = 0; i < 3; i++) sregs[i] = 8'h00;
        hreset_n = 1'b0;
        bus_if.req0_valid = 1'b0;
        bus_if.req0_p0 = 8'h00;
        bus_if.req0_p1 = 8'h00;
        bus_if.req0_size = 5'h00;
        bus_if.req1_valid = 1'b0;
        bus_if.req1_p0 = 8'h00;
        bus_if.req1_p1 = 8'h00;
        bus_if.req1_size = 5'h00;
        bus_if.bus_stall = 1'b0;
        repeat (2) @(posedge hclk);
        #1;
        check("rst_hsel", bus_if.hsel_x, 0);
        check("rst_hwrite", bus_if.hwrite, 0);
        check("rst_hready", bus_if.hready, 0);
        check("rst_ws", bus_if.write_select, 0);
        check("rst_hwdata", bus_if.hwdata, 0);
        check("rst_busy", bus_if.busy, 0);
        check("rst_done", bus_if.done, 0);
        check("rst_done_id", bus_if.done_id, 0);
        check("rst_rdy0", bus_if.req0_ready, 0);
        check("rst_rdy1", bus_if.req1_ready, 0);
        hreset_n = 1'b1;
        @(posedge hclk);
        #1;

        // Single request, unstalled
        send(0, 8'hA5, 8'h3C, 5'h13);
        wait_done(1);
        check("lat_single", done_cyc - hs_cyc, 3);
        check("slave_p0", sregs[0], 8'hA5);
        check("slave_p1", sregs[1], 8'h3C);
        check("slave_size", sregs[2], 8'h13);

        // Full-width size field
        send(0, 8'h11, 8'h22, 5'h1F);
        wait_done(2);
        check("slave_size_max", sregs[2], 8'h1F);

        // Three stall cycles during the payload_0 beat
        p0_writes = 0;
        send(1, 8'h5A, 8'hC3, 5'h07);
        @(posedge hclk);
        #1;
        bus_if.bus_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge hclk);
            check("stall_hready", bus_if.hready, 0);
            check("stall_hwdata", bus_if.hwdata, 8'h5A);
            check("stall_ws", bus_if.write_select, 0);
            @(posedge hclk);
        end
        #1;
        bus_if.bus_stall = 1'b0;
        wait_done(3);
        check("lat_stall", done_cyc - hs_cyc, 6);
        check("p0_writes", p0_writes, 1);
        check("slave_p0_stall", sregs[0], 8'h5A);

        // req1 valid briefly while busy, withdrawn before IDLE
        base = hs_count;
        send(0, 8'h01, 8'h02, 5'h03);
        @(posedge hclk);
        #1;
        bus_if.req1_p0 = 8'hEE;
        bus_if.req1_valid = 1'b1;
        @(posedge hclk);
        #1;
        bus_if.req1_valid = 1'b0;
        wait_done(4);
        repeat (6) @(posedge hclk);
        #1;
        check("withdraw_hs", hs_count - base, 1);
        check("withdraw_done", done_cnt, 4);

        // Reset during payload_0 beat
        dc = done_cnt;
        send(0, 8'h77, 8'h88, 5'h09);
        @(posedge hclk);
        #3;
        hreset_n = 1'b0;
        #1;
        check("mrst_hsel", bus_if.hsel_x, 0);
        check("mrst_hwrite", bus_if.hwrite, 0);
        check("mrst_hready", bus_if.hready, 0);
        check("mrst_ws", bus_if.write_select, 0);
        check("mrst_hwdata", bus_if.hwdata, 0);
        check("mrst_busy", bus_if.busy, 0);
        check("mrst_done", bus_if.done, 0);
        beat_q.delete();
        done_q.delete();
        m_rr = 1'b1;
        @(posedge hclk);
        #1;
        hreset_n = 1'b1;
        repeat (3) @(posedge hclk);
        #1;
        check("mrst_no_done", done_cnt, dc);

        // Both requesters valid continuously for four sequences
        grants.delete();
        hs_cycq.delete();
        both_rdy = 0;
        base = hs_count;
        bus_if.req0_p0 = 8'h10;
        bus_if.req0_p1 = 8'h20;
        bus_if.req0_size = 5'h04;
        bus_if.req1_p0 = 8'h90;
        bus_if.req1_p1 = 8'hA0;
        bus_if.req1_size = 5'h1C;
        bus_if.req0_valid = 1'b1;
        bus_if.req1_valid = 1'b1;
        for (int k = 0; k < 100 && hs_count < base + 4; k++) begin
            @(posedge hclk);
            #1;
        end
        bus_if.req0_valid = 1'b0;
        bus_if.req1_valid = 1'b0;
        check("rr_hs_count", hs_count - base, 4);
        wait_done(dc + 4);
        check("rr_grant_cnt", grants.size(), 4);
        if (grants.size() >= 4) begin
            for (int i = 0; i < 4; i++)
                check($sformatf("rr_grant%0d", i), grants[i], i % 2);
        end
        if (hs_cycq.size() >= 4) begin
            check("rr_hs_span", hs_cycq[3] - hs_cycq[0], 15);
            check("rr_total", done_cyc + 2 - hs_cycq[0], 20);
        end
        check("rr_both_ready", both_rdy, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
